// File: rtl/ysyx_23060221_axi_arbiter_fsm.sv
// Two-master / one-slave AXI4 arbiter: one locked transaction at a time, all channels combinational once granted.
// Optional ARB_ROUND_ROBIN_EN: ties alternate on last_owner; otherwise m0 (IFU) wins ties.
module ysyx_23060221_axi_arbiter_fsm #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    // master 0 (IFU)
    input  logic                m0_arvalid,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic [ID_W-1:0]     m0_arid,
    input  logic [7:0]          m0_arlen,
    input  logic [2:0]          m0_arsize,
    input  logic [1:0]          m0_arburst,
    output logic                m0_arready,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic                m0_rlast,
    output logic [ID_W-1:0]     m0_rid,
    input  logic                m0_rready,
    input  logic                m0_awvalid,
    input  logic [ADDR_W-1:0]   m0_awaddr,
    input  logic [ID_W-1:0]     m0_awid,
    input  logic [7:0]          m0_awlen,
    input  logic [2:0]          m0_awsize,
    input  logic [1:0]          m0_awburst,
    output logic                m0_awready,
    input  logic                m0_wvalid,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    input  logic                m0_wlast,
    output logic                m0_wready,
    output logic                m0_bvalid,
    output logic [1:0]          m0_bresp,
    output logic [ID_W-1:0]     m0_bid,
    input  logic                m0_bready,
    // master 1 (EXU/LSU)
    input  logic                m1_arvalid,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic [ID_W-1:0]     m1_arid,
    input  logic [7:0]          m1_arlen,
    input  logic [2:0]          m1_arsize,
    input  logic [1:0]          m1_arburst,
    output logic                m1_arready,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic                m1_rlast,
    output logic [ID_W-1:0]     m1_rid,
    input  logic                m1_rready,
    input  logic                m1_awvalid,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic [ID_W-1:0]     m1_awid,
    input  logic [7:0]          m1_awlen,
    input  logic [2:0]          m1_awsize,
    input  logic [1:0]          m1_awburst,
    output logic                m1_awready,
    input  logic                m1_wvalid,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wlast,
    output logic                m1_wready,
    output logic                m1_bvalid,
    output logic [1:0]          m1_bresp,
    output logic [ID_W-1:0]     m1_bid,
    input  logic                m1_bready,
    // slave port
    output logic                s_arvalid,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic [ID_W-1:0]     s_arid,
    output logic [7:0]          s_arlen,
    output logic [2:0]          s_arsize,
    output logic [1:0]          s_arburst,
    input  logic                s_arready,
    input  logic                s_rvalid,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rlast,
    input  logic [ID_W-1:0]     s_rid,
    output logic                s_rready,
    output logic                s_awvalid,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic [ID_W-1:0]     s_awid,
    output logic [7:0]          s_awlen,
    output logic [2:0]          s_awsize,
    output logic [1:0]          s_awburst,
    input  logic                s_awready,
    output logic                s_wvalid,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wlast,
    input  logic                s_wready,
    input  logic                s_bvalid,
    input  logic [1:0]          s_bresp,
    input  logic [ID_W-1:0]     s_bid,
    output logic                s_bready,
    output logic [1:0]          grant_o
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_owner_q, last_owner_d;
    logic   ar_done_q, ar_done_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;

    logic req0, req1, tie_winner, winner, win_ar;
    logic ar_hs, aw_hs, w_last_hs, r_last_hs, b_hs;

    // Request side of the current owner.
    logic                own_arvalid, own_rready, own_awvalid, own_wvalid, own_wlast, own_bready;
    logic [ADDR_W-1:0]   own_araddr, own_awaddr;
    logic [ID_W-1:0]     own_arid, own_awid;
    logic [7:0]          own_arlen, own_awlen;
    logic [2:0]          own_arsize, own_awsize;
    logic [1:0]          own_arburst, own_awburst;
    logic [DATA_W-1:0]   own_wdata;
    logic [DATA_W/8-1:0] own_wstrb;

    assign own_arvalid = owner_q ? m1_arvalid : m0_arvalid;
    assign own_araddr  = owner_q ? m1_araddr  : m0_araddr;
    assign own_arid    = owner_q ? m1_arid    : m0_arid;
    assign own_arlen   = owner_q ? m1_arlen   : m0_arlen;
    assign own_arsize  = owner_q ? m1_arsize  : m0_arsize;
    assign own_arburst = owner_q ? m1_arburst : m0_arburst;
    assign own_rready  = owner_q ? m1_rready  : m0_rready;
    assign own_awvalid = owner_q ? m1_awvalid : m0_awvalid;
    assign own_awaddr  = owner_q ? m1_awaddr  : m0_awaddr;
    assign own_awid    = owner_q ? m1_awid    : m0_awid;
    assign own_awlen   = owner_q ? m1_awlen   : m0_awlen;
    assign own_awsize  = owner_q ? m1_awsize  : m0_awsize;
    assign own_awburst = owner_q ? m1_awburst : m0_awburst;
    assign own_wvalid  = owner_q ? m1_wvalid  : m0_wvalid;
    assign own_wdata   = owner_q ? m1_wdata   : m0_wdata;
    assign own_wstrb   = owner_q ? m1_wstrb   : m0_wstrb;
    assign own_wlast   = owner_q ? m1_wlast   : m0_wlast;
    assign own_bready  = owner_q ? m1_bready  : m0_bready;

    assign req0 = m0_arvalid | m0_awvalid;
    assign req1 = m1_arvalid | m1_awvalid;

`ifdef ARB_ROUND_ROBIN_EN
    assign tie_winner = ~last_owner_q;
`else
    // last_owner is kept up to date in both builds; only the round-robin tie-break reads it.
    logic unused_last_owner;
    assign unused_last_owner = last_owner_q;
    assign tie_winner        = 1'b0;
`endif

    assign winner = (req0 & req1) ? tie_winner : req1;
    assign win_ar = winner ? m1_arvalid : m0_arvalid;

    assign ar_hs     = s_arvalid & s_arready;
    assign aw_hs     = s_awvalid & s_awready;
    assign w_last_hs = s_wvalid & s_wready & s_wlast;
    assign r_last_hs = s_rvalid & s_rready & s_rlast;
    assign b_hs      = s_bvalid & s_bready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            ar_done_q    <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            ar_done_q    <= ar_done_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        ar_done_d    = ar_done_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    owner_d = winner;
                    state_d = win_ar ? READ : WRITE;
                end
            end
            READ: begin
                if (ar_hs) ar_done_d = 1'b1;
                if (r_last_hs) begin
                    state_d      = IDLE;
                    ar_done_d    = 1'b0;
                    last_owner_d = owner_q;
                end
            end
            WRITE: begin
                if (aw_hs)     aw_done_d = 1'b1;
                if (w_last_hs) w_done_d  = 1'b1;
                if (b_hs) begin
                    state_d      = IDLE;
                    aw_done_d    = 1'b0;
                    w_done_d     = 1'b0;
                    last_owner_d = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Everything is zero unless a transaction is locked; the non-owner always sees zeros.
    always_comb begin
        grant_o   = 2'b00;
        s_arvalid = 1'b0; s_araddr = '0; s_arid = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
        s_rready  = 1'b0;
        s_awvalid = 1'b0; s_awaddr = '0; s_awid = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0;
        s_wvalid  = 1'b0; s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0;
        s_bready  = 1'b0;
        m0_arready = 1'b0; m0_rvalid = 1'b0; m0_rdata = '0; m0_rresp = '0; m0_rlast = 1'b0; m0_rid = '0;
        m0_awready = 1'b0; m0_wready = 1'b0; m0_bvalid = 1'b0; m0_bresp = '0; m0_bid = '0;
        m1_arready = 1'b0; m1_rvalid = 1'b0; m1_rdata = '0; m1_rresp = '0; m1_rlast = 1'b0; m1_rid = '0;
        m1_awready = 1'b0; m1_wready = 1'b0; m1_bvalid = 1'b0; m1_bresp = '0; m1_bid = '0;
        case (state_q)
            READ: begin
                grant_o   = {owner_q, ~owner_q};
                s_arvalid = own_arvalid & ~ar_done_q;
                s_araddr  = own_araddr;
                s_arid    = own_arid;
                s_arlen   = own_arlen;
                s_arsize  = own_arsize;
                s_arburst = own_arburst;
                s_rready  = own_rready;
                if (owner_q) begin
                    m1_arready = s_arready & ~ar_done_q;
                    m1_rvalid  = s_rvalid;
                    m1_rdata   = s_rdata;
                    m1_rresp   = s_rresp;
                    m1_rlast   = s_rlast;
                    m1_rid     = s_rid;
                end else begin
                    m0_arready = s_arready & ~ar_done_q;
                    m0_rvalid  = s_rvalid;
                    m0_rdata   = s_rdata;
                    m0_rresp   = s_rresp;
                    m0_rlast   = s_rlast;
                    m0_rid     = s_rid;
                end
            end
            WRITE: begin
                grant_o   = {owner_q, ~owner_q};
                s_awvalid = own_awvalid & ~aw_done_q;
                s_awaddr  = own_awaddr;
                s_awid    = own_awid;
                s_awlen   = own_awlen;
                s_awsize  = own_awsize;
                s_awburst = own_awburst;
                s_wvalid  = own_wvalid & ~w_done_q;
                s_wdata   = own_wdata;
                s_wstrb   = own_wstrb;
                s_wlast   = own_wlast;
                s_bready  = own_bready;
                if (owner_q) begin
                    m1_awready = s_awready & ~aw_done_q;
                    m1_wready  = s_wready & ~w_done_q;
                    m1_bvalid  = s_bvalid;
                    m1_bresp   = s_bresp;
                    m1_bid     = s_bid;
                end else begin
                    m0_awready = s_awready & ~aw_done_q;
                    m0_wready  = s_wready & ~w_done_q;
                    m0_bvalid  = s_bvalid;
                    m0_bresp   = s_bresp;
                    m0_bid     = s_bid;
                end
            end
            default: ;
        endcase
    end

endmodule
